instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Front-end stage of the datapath, directly upstream of the instruction register and decode.
- Owns the program counter and drives the instruction-memory request/response interface.
- Buffers returned instruction words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts PC redirects (branch/jump) from later stages and flushes in-flight work.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instruction words
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >= 2)

Ports:
ifu_clock_in  input  1  clock; all state on rising edge
ifu_reset_in  input  1  asynchronous, active-high reset
ifu_redirect_in  input  1  load PC from redirect address this cycle
ifu_redirect_addr_in  input  DATA_WIDTH  redirect target
ifu_mem_req_out  output  1  instruction-memory request valid
ifu_mem_addr_out  output  DATA_WIDTH  request address (current fetch PC)
ifu_mem_gnt_in  input  1  memory accepted request this cycle
ifu_mem_rvalid_in  input  1  response data valid (in order, >= 1 cycle after gnt)
ifu_mem_rdata_in  input  DATA_WIDTH  response instruction word
ifu_ins_valid_out  output  1  instruction available to decode
ifu_ins_data_out  output  DATA_WIDTH  instruction word (FIFO head)
ifu_ins_pc_out  output  DATA_WIDTH  PC of that instruction
ifu_ins_ready_in  input  1  decode consumes head this cycle

Behaviour:
- Reset (async, active-high): fetch PC = RESET_VECTOR; FIFO empty; outstanding = 0; drop = 0; all outputs 0 except ifu_mem_addr_out = RESET_VECTOR.
- One outstanding memory request max; no new request until the previous response arrives.
- Request FSM states:
  - REQ: ifu_mem_req_out=1, addr = fetch PC. Entered only when (FIFO count + outstanding) < FIFO_DEPTH.
  - WAIT: request granted, awaiting rvalid.
  - HOLD: no slot free.
- Transitions:
  - REQ -> WAIT on gnt; fetch PC += 4 at the same edge. req/addr stay stable until gnt.
  - WAIT -> REQ on rvalid if a slot is free, else -> HOLD. A new request is issued the cycle after rvalid.
  - HOLD -> REQ when a pop frees a slot.
- Response: an rvalid word with drop=0 is written to FIFO with its PC at that edge; ifu_ins_valid_out rises the following cycle. A slot is reserved at issue, so a push never finds the FIFO full.
- Handshake: pop when valid & ready; head data/PC stable while valid & !ready. Push and pop in the same cycle are both allowed; count is unchanged.
- Redirect (highest priority):
  - FIFO is flushed and ifu_ins_valid_out = 0 next cycle.
  - Fetch PC = redirect address (see optional feature for low bits).
  - If a request is granted but unreturned (WAIT, or gnt in the redirect cycle), drop is set and that response is discarded; drop clears on that rvalid.
  - FSM goes to REQ (or WAIT-for-drop then REQ) with the new PC.
  - Redirect with rvalid in the same cycle: the word is discarded.
  - Redirect while in REQ without gnt: the address changes next cycle; memory samples the address only at gnt.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Latency: with gnt same cycle and rvalid the cycle after gnt, the first instruction is valid 3 cycles after reset release. Steady state is one instruction per 2 cycles.

Optional Feature:
- Macro: IFU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output ifu_misaligned_out (1 bit, reset 0).
  - A redirect with addr[1:0] != 0 sets it sticky, flushes as normal, and suppresses all requests.
  - The next aligned redirect clears it and resumes fetch.
- Undefined: no port; redirect addr[1:0] is forced to 2'b00 and fetch continues.

Test Plan:
- Reset release, memory gnt immediate, rvalid +1 cycle, ready=1 -> requests at 0x0, 0x4, 0x8; ins_pc_out 0x0, 0x4, 0x8 with matching rdata, in order.
- ready=0 held -> after 2 words, req_out stays 0 (HOLD); ins_data_out/ins_pc_out stable. Ready=1 for one cycle -> one pop, then exactly one new request.
- Redirect to 0x100 while in WAIT for 0x8 -> 0x8 response discarded, FIFO empty next cycle; next request addr 0x100; first valid PC 0x100.
- Redirect coincident with rvalid -> word not delivered; no valid output carries the stale PC.
- Redirect to 0xFFFF_FFFC -> delivers PCs 0xFFFF_FFFC then 0x0000_0000.
- Async reset asserted mid-WAIT with FIFO holding 1 entry -> outputs zero immediately (no clock); after release, fetch restarts at RESET_VECTOR.
- Redirect to 0x102: with IFU_MISALIGN_TRAP_EN, misaligned_out=1 and no requests; a later redirect to 0x200 resumes. Without it, fetch proceeds at 0x100.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Instruction fetch unit bus: redirect input, instruction-memory req/gnt/rvalid, decode valid/ready.
// Pure wiring bundle, no latency of its own.
// Backpressure is carried by ifu_mem_gnt_in (memory side) and ifu_ins_ready_in (decode side).
// IFU_MISALIGN_TRAP_EN adds the ifu_misaligned_out status line.
interface instruction_fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ifu_redirect_in;
  logic [DATA_WIDTH-1:0] ifu_redirect_addr_in;
  logic                  ifu_mem_req_out;
  logic [DATA_WIDTH-1:0] ifu_mem_addr_out;
  logic                  ifu_mem_gnt_in;
  logic                  ifu_mem_rvalid_in;
  logic [DATA_WIDTH-1:0] ifu_mem_rdata_in;
  logic                  ifu_ins_valid_out;
  logic [DATA_WIDTH-1:0] ifu_ins_data_out;
  logic [DATA_WIDTH-1:0] ifu_ins_pc_out;
  logic                  ifu_ins_ready_in;
`ifdef IFU_MISALIGN_TRAP_EN
  logic                  ifu_misaligned_out;
`endif

  // Fetch unit side.
  modport ifu (
`ifdef IFU_MISALIGN_TRAP_EN
    output ifu_misaligned_out,
`endif
    input  ifu_redirect_in, ifu_redirect_addr_in,
    output ifu_mem_req_out, ifu_mem_addr_out,
    input  ifu_mem_gnt_in, ifu_mem_rvalid_in, ifu_mem_rdata_in,
    output ifu_ins_valid_out, ifu_ins_data_out, ifu_ins_pc_out,
    input  ifu_ins_ready_in
  );

  // Memory / decode / redirect-source side.
  modport env (
`ifdef IFU_MISALIGN_TRAP_EN
    input  ifu_misaligned_out,
`endif
    output ifu_redirect_in, ifu_redirect_addr_in,
    input  ifu_mem_req_out, ifu_mem_addr_out,
    output ifu_mem_gnt_in, ifu_mem_rvalid_in, ifu_mem_rdata_in,
    input  ifu_ins_valid_out, ifu_ins_data_out, ifu_ins_pc_out,
    output ifu_ins_ready_in
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues one memory request at a time, buffers words for decode.
// Latency: request the cycle after a slot frees; word visible to decode the cycle after rvalid.
// Backpressure: decode ready=0 fills the FIFO, then requests stop (slots reserved at issue).
// Optional macro IFU_MISALIGN_TRAP_EN: misaligned redirects trap (sticky flag, fetch suppressed).
module instruction_fetch_unit #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = {DATA_WIDTH{1'b0}},
  parameter int unsigned           FIFO_DEPTH   = 2
) (
  input logic                 ifu_clock_in,
  input logic                 ifu_reset_in,
  instruction_fetch_unit_if.ifu bus
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] req_pc;     // PC of the request currently in flight
  logic                  drop;       // in-flight response belongs to a flushed stream
  logic                  trap_q;

  logic [DATA_WIDTH-1:0] fifo_dat [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_pc  [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;

  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  slot_free;
  logic                  can_issue;
  logic                  inflight_lost;
  logic                  redir_misaligned;
  logic [DATA_WIDTH-1:0] redir_pc;

  assign flush = bus.ifu_redirect_in;
  assign pop   = bus.ifu_ins_valid_out && bus.ifu_ins_ready_in;
  // A response is kept only if it belongs to the live stream and no redirect is flushing now.
  assign push  = (state == S_WAIT) && bus.ifu_mem_rvalid_in && !drop && !flush;

`ifdef IFU_MISALIGN_TRAP_EN
  assign redir_misaligned = (bus.ifu_redirect_addr_in[1:0] != 2'b00);
  assign redir_pc         = bus.ifu_redirect_addr_in;

  // Sticky misalignment flag: every redirect overwrites it with its own alignment check.
  always_ff @(posedge ifu_clock_in or posedge ifu_reset_in) begin
    if (ifu_reset_in) begin
      trap_q <= 1'b0;
    end else if (bus.ifu_redirect_in) begin
      trap_q <= redir_misaligned;
    end
  end

  assign bus.ifu_misaligned_out = trap_q;
`else
  // Without the trap, the low address bits are simply ignored.
  assign redir_misaligned = 1'b0;
  assign redir_pc         = bus.ifu_redirect_addr_in & ~DATA_WIDTH'(3);
  assign trap_q           = 1'b0;
`endif

  // Occupancy after this edge; issue decisions use it so a pop frees a slot immediately.
  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  // Outstanding is zero whenever a new request is considered, so count alone decides.
  assign slot_free     = (count_nxt < CW'(FIFO_DEPTH));
  assign can_issue     = slot_free && !trap_q;
  // Granted-but-unreturned request at redirect time: its response must be discarded.
  assign inflight_lost = ((state == S_WAIT) && !bus.ifu_mem_rvalid_in) ||
                         ((state == S_REQ)  && bus.ifu_mem_gnt_in);

  // Request FSM with fetch PC, in-flight PC and drop flag; redirect overrides all else.
  always_ff @(posedge ifu_clock_in or posedge ifu_reset_in) begin
    if (ifu_reset_in) begin
      state    <= S_HOLD;
      fetch_pc <= RESET_VECTOR;
      req_pc   <= RESET_VECTOR;
      drop     <= 1'b0;
    end else if (bus.ifu_redirect_in) begin
      fetch_pc <= redir_pc;
      if (inflight_lost) begin
        drop  <= 1'b1;
        state <= S_WAIT;
      end else begin
        drop  <= 1'b0;
        state <= redir_misaligned ? S_HOLD : S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (bus.ifu_mem_gnt_in) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + DATA_WIDTH'(4);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.ifu_mem_rvalid_in) begin
            drop  <= 1'b0;
            state <= can_issue ? S_REQ : S_HOLD;
          end
        end
        S_HOLD: begin
          if (can_issue) begin
            state <= S_REQ;
          end
        end
        default: state <= S_HOLD;
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer in one edge.
  always_ff @(posedge ifu_clock_in or posedge ifu_reset_in) begin
    if (ifu_reset_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  // FIFO storage; contents are don't-care until marked valid by count.
  always_ff @(posedge ifu_clock_in) begin
    if (push) begin
      fifo_dat[wr_ptr] <= bus.ifu_mem_rdata_in;
      fifo_pc[wr_ptr]  <= req_pc;
    end
  end

  assign bus.ifu_mem_req_out   = (state == S_REQ);
  assign bus.ifu_mem_addr_out  = fetch_pc;
  assign bus.ifu_ins_valid_out = (count != '0);
  // Head is forced to zero when empty so reset clears the outputs without resetting storage.
  assign bus.ifu_ins_data_out  = bus.ifu_ins_valid_out ? fifo_dat[rd_ptr] : '0;
  assign bus.ifu_ins_pc_out    = bus.ifu_ins_valid_out ? fifo_pc[rd_ptr]  : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural instruction memory.
// Expected PCs are queued as each step is driven and checked as decode pops them.
module tb_instruction_fetch_unit;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   pops  = 0;
  int   grants_left = 0;
  int   rsp_lat = 1;
  logic [31:0] exp_q[$];
  logic [31:0] gnt_log[$];

  instruction_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

  instruction_fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_VECTOR(32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .ifu_clock_in(clk),
    .ifu_reset_in(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_pops(input string tag, input int n);
    int b = 0;
    while (pops < n && b < 200) begin
      tick(1);
      b++;
    end
    check(tag, pops, n);
  endtask

  task automatic wait_gnts(input string tag, input int n);
    int b = 0;
    while (gnt_log.size() < n && b < 200) begin
      tick(1);
      b++;
    end
    check(tag, gnt_log.size(), n);
  endtask

  // Grants whenever the grant budget allows; gnt is combinational from req.
  assign bus.ifu_mem_gnt_in = bus.ifu_mem_req_out && (grants_left != 0);

  // Memory model: one response rsp_lat cycles after each grant.
  initial begin
    logic        fire;
    logic [31:0] faddr;
    logic [31:0] paddr;
    int          pend;
    bus.ifu_mem_rvalid_in = 1'b0;
    bus.ifu_mem_rdata_in  = '0;
    paddr = '0;
    pend  = 0;
    forever begin
      @(negedge clk);
      fire  = bus.ifu_mem_req_out && bus.ifu_mem_gnt_in;
      faddr = bus.ifu_mem_addr_out;
      @(posedge clk);
      #1;
      bus.ifu_mem_rvalid_in = 1'b0;
      if (rst) begin
        pend = 0;
      end else begin
        if (fire) begin
          gnt_log.push_back(faddr);
          grants_left--;
          paddr = faddr;
          pend  = rsp_lat;
        end
        if (pend != 0) begin
          pend--;
          if (pend == 0) begin
            bus.ifu_mem_rvalid_in = 1'b1;
            bus.ifu_mem_rdata_in  = word(paddr);
          end
        end
      end
    end
  end

  // Decode-side scoreboard: every accepted instruction must be the next expected PC.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && bus.ifu_ins_valid_out && bus.ifu_ins_ready_in) begin
        pops++;
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL out_extra: observed pc %h, expected no output", bus.ifu_ins_pc_out);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_pc", bus.ifu_ins_pc_out, e);
          check("out_data", bus.ifu_ins_data_out, word(e));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.ifu_redirect_in      = 1'b0;
    bus.ifu_redirect_addr_in = '0;
    bus.ifu_ins_ready_in     = 1'b1;

    // Reset state
    #2;
    check("rst_req", bus.ifu_mem_req_out, 0);
    check("rst_addr", bus.ifu_mem_addr_out, 32'h0);
    check("rst_valid", bus.ifu_ins_valid_out, 0);
    check("rst_data", bus.ifu_ins_data_out, 0);
    check("rst_pc", bus.ifu_ins_pc_out, 0);
    tick(2);

    // Streaming from reset: 0x0, 0x4, 0x8
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    grants_left = 3;
    rst = 1'b0;
    tick(1);
    check("t1_req_first", bus.ifu_mem_req_out, 1);
    check("t1_addr_first", bus.ifu_mem_addr_out, 32'h0);
    tick(1);
    check("t1_valid_c2", bus.ifu_ins_valid_out, 0);
    tick(1);
    check("t1_valid_c3", bus.ifu_ins_valid_out, 1);
    wait_pops("t1_pops", 3);
    check("t1_gnt0", gnt_log[0], 32'h0);
    check("t1_gnt1", gnt_log[1], 32'h4);
    check("t1_gnt2", gnt_log[2], 32'h8);

    // Backpressure: two words fill the FIFO, then HOLD
    bus.ifu_ins_ready_in = 1'b0;
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    grants_left = 2;
    wait_gnts("t2_gnts", 5);
    tick(4);
    check("t2_hold_req", bus.ifu_mem_req_out, 0);
    check("t2_head_valid", bus.ifu_ins_valid_out, 1);
    check("t2_head_pc", bus.ifu_ins_pc_out, 32'hC);
    tick(3);
    check("t2_stable_pc", bus.ifu_ins_pc_out, 32'hC);
    check("t2_stable_data", bus.ifu_ins_data_out, word(32'hC));
    grants_left = 1;
    bus.ifu_ins_ready_in = 1'b1;
    tick(1);
    bus.ifu_ins_ready_in = 1'b0;
    tick(6);
    check("t2_one_pop", pops, 4);
    check("t2_one_req", gnt_log.size(), 6);
    check("t2_req_addr", gnt_log[5], 32'h14);
    check("t2_rehold_req", bus.ifu_mem_req_out, 0);
    check("t2_next_pc", bus.ifu_ins_pc_out, 32'h10);

    // Redirect while waiting on a slow response; FIFO holds 0x14 which is flushed
    rsp_lat = 4;
    grants_left = 1;
    bus.ifu_ins_ready_in = 1'b1;
    tick(1);
    bus.ifu_ins_ready_in = 1'b0;
    wait_gnts("t3_gnts", 7);
    check("t3_gnt_addr", gnt_log[6], 32'h18);
    bus.ifu_redirect_in      = 1'b1;
    bus.ifu_redirect_addr_in = 32'h100;
    tick(1);
    bus.ifu_redirect_in = 1'b0;
    check("t3_flush_valid", bus.ifu_ins_valid_out, 0);
    check("t3_new_addr", bus.ifu_mem_addr_out, 32'h100);
    check("t3_no_req_wait", bus.ifu_mem_req_out, 0);
    rsp_lat = 1;
    grants_left = 2;
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    bus.ifu_ins_ready_in = 1'b1;
    wait_pops("t3_pops", 7);
    check("t3_gnt_100", gnt_log[7], 32'h100);
    check("t3_gnt_104", gnt_log[8], 32'h104);

    // Redirect in the same cycle as rvalid: the word is dropped
    rsp_lat = 3;
    grants_left = 2;
    exp_q.push_back(32'h200);
    begin
      int b = 0;
      while (bus.ifu_mem_rvalid_in !== 1'b1 && b < 20) begin
        tick(1);
        b++;
      end
    end
    check("t4_rvalid_seen", bus.ifu_mem_rvalid_in, 1);
    bus.ifu_redirect_in      = 1'b1;
    bus.ifu_redirect_addr_in = 32'h200;
    rsp_lat = 1;
    tick(1);
    bus.ifu_redirect_in = 1'b0;
    check("t4_valid_after", bus.ifu_ins_valid_out, 0);
    wait_pops("t4_pops", 8);
    check("t4_gnt_108", gnt_log[9], 32'h108);
    check("t4_gnt_200", gnt_log[10], 32'h200);

    // PC wrap; redirect while in REQ without gnt
    bus.ifu_redirect_in      = 1'b1;
    bus.ifu_redirect_addr_in = 32'hFFFF_FFFC;
    tick(1);
    bus.ifu_redirect_in = 1'b0;
    check("t5_addr", bus.ifu_mem_addr_out, 32'hFFFF_FFFC);
    check("t5_req", bus.ifu_mem_req_out, 1);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    grants_left = 2;
    wait_pops("t5_pops", 10);
    check("t5_gnt_top", gnt_log[11], 32'hFFFF_FFFC);
    check("t5_gnt_wrap", gnt_log[12], 32'h0);

    // Async reset in WAIT with one buffered entry
    bus.ifu_ins_ready_in = 1'b0;
    rsp_lat = 4;
    grants_left = 2;
    wait_gnts("t6_gnts", 15);
    check("t6_pre_valid", bus.ifu_ins_valid_out, 1);
    check("t6_pre_pc", bus.ifu_ins_pc_out, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_req", bus.ifu_mem_req_out, 0);
    check("t6_async_valid", bus.ifu_ins_valid_out, 0);
    check("t6_async_data", bus.ifu_ins_data_out, 0);
    check("t6_async_pc", bus.ifu_ins_pc_out, 0);
    check("t6_async_addr", bus.ifu_mem_addr_out, 32'h0);
    rsp_lat = 1;
    grants_left = 2;
    bus.ifu_ins_ready_in = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick(2);
    rst = 1'b0;
    wait_pops("t6_pops", 12);
    check("t6_gnt_0", gnt_log[15], 32'h0);
    check("t6_gnt_4", gnt_log[16], 32'h4);

    // Misaligned redirect
    bus.ifu_redirect_in      = 1'b1;
    bus.ifu_redirect_addr_in = 32'h102;
    tick(1);
    bus.ifu_redirect_in = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    check("t7_trap_set", bus.ifu_misaligned_out, 1);
    check("t7_trap_req", bus.ifu_mem_req_out, 0);
    tick(5);
    check("t7_trap_still_req", bus.ifu_mem_req_out, 0);
    check("t7_trap_sticky", bus.ifu_misaligned_out, 1);
    check("t7_trap_no_gnt", gnt_log.size(), 17);
    bus.ifu_redirect_in      = 1'b1;
    bus.ifu_redirect_addr_in = 32'h200;
    tick(1);
    bus.ifu_redirect_in = 1'b0;
    check("t7_trap_clear", bus.ifu_misaligned_out, 0);
    check("t7_resume_req", bus.ifu_mem_req_out, 1);
    check("t7_resume_addr", bus.ifu_mem_addr_out, 32'h200);
    exp_q.push_back(32'h200);
    grants_left = 1;
    wait_pops("t7_pops", 13);
    check("t7_gnt", gnt_log[17], 32'h200);
`else
    check("t7_align_addr", bus.ifu_mem_addr_out, 32'h100);
    check("t7_align_req", bus.ifu_mem_req_out, 1);
    exp_q.push_back(32'h100);
    grants_left = 1;
    wait_pops("t7_pops", 13);
    check("t7_gnt", gnt_log[17], 32'h100);
`endif

    tick(3);
    check("end_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
